// File: rtl/sram_pack_fifo_ctrl.sv
// Packs 32-bit words into 128-bit rows of an external 1W1R SRAM and streams closed rows out in order.
// Define SRAM_PACK_FLUSH_EN to let in_last close a partial row early; otherwise rows always carry four lanes.
module sram_pack_fifo_ctrl #(
    parameter int DEPTH      = 28,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk0,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          out_data,
    output logic [3:0]            out_lanes,
    output logic                  csb0,
    output logic [3:0]            wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [127:0]          din0,
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [127:0]          dout1,
    output logic [5:0]            rows
);
    localparam logic [5:0]            FULL_ROWS = 6'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW  = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} rd_state_t;

    rd_state_t             state;
    logic [ADDR_WIDTH-1:0] wr_row;
    logic [ADDR_WIDTH-1:0] rd_row;
    logic [1:0]            lane;
    logic [3:0]            lane_bit;
    logic [3:0]            rd_mask;
    logic                  accept;
    logic                  close;
    logic                  pop;

    // in_ready is forced low while reset is held, independent of the row count
    assign in_ready = rst_n && (rows < FULL_ROWS);
    assign accept   = in_valid && in_ready;
    assign lane_bit = 4'b0001 << lane;
`ifdef SRAM_PACK_FLUSH_EN
    assign close    = accept && ((lane == 2'd3) || in_last);
`else
    assign close    = accept && (lane == 2'd3);
`endif
    assign pop      = (state == HOLD) && out_ready;

    assign csb0      = !accept;
    assign wmask0    = accept ? lane_bit : 4'b0000;
    assign addr0     = wr_row;
    assign din0      = {4{in_data}};
    assign csb1      = !((state == IDLE) && (rows != 6'd0));
    assign addr1     = rd_row;
    assign out_valid = (state == HOLD);

    // write side: lane and row pointers
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            wr_row <= '0;
            lane   <= 2'd0;
        end else if (accept) begin
            if (close) begin
                lane   <= 2'd0;
                wr_row <= (wr_row == LAST_ROW) ? '0 : wr_row + 1'b1;
            end else begin
                lane   <= lane + 2'd1;
            end
        end
    end

`ifdef SRAM_PACK_FLUSH_EN
    logic [3:0] acc_mask;
    logic [3:0] mask_mem [DEPTH];

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            acc_mask <= 4'b0000;
        end else if (accept) begin
            acc_mask <= close ? 4'b0000 : (acc_mask | lane_bit);
        end
    end

    // mask store is data only; stale entries are never read before being rewritten
    always_ff @(posedge clk0) begin
        if (close) begin
            mask_mem[wr_row] <= acc_mask | lane_bit;
        end
    end

    assign rd_mask = mask_mem[rd_row];
`else
    assign rd_mask = 4'hF;
`endif

    // read side: occupancy count and IDLE -> FETCH -> HOLD sequencer
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_row    <= '0;
            rows      <= 6'd0;
            out_data  <= '0;
            out_lanes <= 4'b0000;
        end else begin
            case ({close, pop})
                2'b10:   rows <= rows + 6'd1;
                2'b01:   rows <= rows - 6'd1;
                default: rows <= rows;
            endcase
            case (state)
                IDLE: begin
                    if (rows != 6'd0) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    out_data  <= dout1;
                    out_lanes <= rd_mask;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        rd_row <= (rd_row == LAST_ROW) ? '0 : rd_row + 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
